// File: rtl/key_writeback_pkg.sv
// =============================================================================
// Module   : key_writeback_pkg
// Purpose  : Shared widths, PHV/value/config layouts and slot indices for key_writeback.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

package key_writeback_pkg;

    localparam int PHV_LEN   = 1124;
    localparam int KEY_LEN   = 197;
    localparam int KEY_OFF   = 18;
    localparam int TID_LSB   = 0;
    localparam int TID_W     = 4;
    localparam int TBL_DEPTH = 16;
    localparam int MASK_W    = 6;
    localparam int OFF_W     = 3;
    localparam int CFG_W     = KEY_OFF + MASK_W;

    localparam int NUM_CONT  = 8;
    localparam int W16       = 16;
    localparam int W32       = 32;
    localparam int W48       = 48;
    localparam int META_LEN  = 356;
    localparam int BASE16    = META_LEN;
    localparam int BASE32    = BASE16 + NUM_CONT * W16;
    localparam int BASE48    = BASE32 + NUM_CONT * W32;

    // Value vector: {48a, 48b, 32a, 32b, 16a, 16b, cond}
    localparam int COND_W    = 5;
    localparam int VAL16B_LSB = COND_W;
    localparam int VAL16A_LSB = VAL16B_LSB + W16;
    localparam int VAL32B_LSB = VAL16A_LSB + W16;
    localparam int VAL32A_LSB = VAL32B_LSB + W32;
    localparam int VAL48B_LSB = VAL32A_LSB + W32;
    localparam int VAL48A_LSB = VAL48B_LSB + W48;

    localparam int CFG_MASK_LSB = 0;
    localparam int CFG_OFF_LSB  = MASK_W;

    // Mask bit / slot index of each value field
    localparam int SLOT_16B = 0;
    localparam int SLOT_16A = 1;
    localparam int SLOT_32B = 2;
    localparam int SLOT_32A = 3;
    localparam int SLOT_48B = 4;
    localparam int SLOT_48A = 5;

    typedef struct packed {
        logic [OFF_W-1:0]  off48a;
        logic [OFF_W-1:0]  off48b;
        logic [OFF_W-1:0]  off32a;
        logic [OFF_W-1:0]  off32b;
        logic [OFF_W-1:0]  off16a;
        logic [OFF_W-1:0]  off16b;
        logic [MASK_W-1:0] mask;
    } cfg_entry_t;

endpackage

`default_nettype wire

// File: rtl/key_wb_cfg_ram.sv
// =============================================================================
// Module   : key_wb_cfg_ram
// Purpose  : 16x24 per-tenant config table, one write port, one registered read port.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module key_wb_cfg_ram
    import key_writeback_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [TID_W-1:0] wr_addr,
    input  logic [CFG_W-1:0] wr_data,
    input  logic [TID_W-1:0] rd_addr,
    output logic [CFG_W-1:0] rd_data
);

    logic [CFG_W-1:0] mem_q [TBL_DEPTH];
    logic [CFG_W-1:0] rd_data_d;
    logic [CFG_W-1:0] rd_data_q;

    always_comb begin
        rd_data_d = mem_q[rd_addr];
    end

    // Read samples the pre-write contents, so a same-address collision returns the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/key_writeback.sv
// =============================================================================
// Module   : key_writeback
// Purpose  : 2-stage per-tenant writeback of action values into PHV containers.
//            Optional KEY_WB_CONFLICT_CHK_EN adds conflict_out.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module key_writeback
    import key_writeback_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_valid_in,
    input  logic [KEY_LEN-1:0] val_in,
    input  logic               val_valid_in,
    input  logic               cfg_wr_en,
    input  logic [TID_W-1:0]   cfg_addr,
    input  logic [CFG_W-1:0]   cfg_data,
    output logic [PHV_LEN-1:0] phv_out,
`ifdef KEY_WB_CONFLICT_CHK_EN
    output logic               conflict_out,
`endif
    output logic               phv_valid_out
);

    localparam int PAY_W = KEY_LEN - COND_W;

    // Payload offsets once the condition bits are stripped
    localparam int P16B = VAL16B_LSB - COND_W;
    localparam int P16A = VAL16A_LSB - COND_W;
    localparam int P32B = VAL32B_LSB - COND_W;
    localparam int P32A = VAL32A_LSB - COND_W;
    localparam int P48B = VAL48B_LSB - COND_W;
    localparam int P48A = VAL48A_LSB - COND_W;

    logic               s1_valid_d,     s1_valid_q;
    logic               s1_val_valid_d, s1_val_valid_q;
    logic [PHV_LEN-1:0] s1_phv_d,       s1_phv_q;
    logic [PAY_W-1:0]   s1_val_d,       s1_val_q;
    logic [PHV_LEN-1:0] phv_out_d,      phv_out_q;
    logic               phv_valid_out_d, phv_valid_out_q;

    logic [CFG_W-1:0]   cfg_rd_data;
    cfg_entry_t         s1_cfg;
    logic [MASK_W-1:0]  slot_en;
    logic [PHV_LEN-1:0] merged;
    logic               unused_cond;

    assign unused_cond = ^val_in[COND_W-1:0];

    key_wb_cfg_ram u_cfg_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cfg_wr_en),
        .wr_addr (cfg_addr),
        .wr_data (cfg_data),
        .rd_addr (phv_in[TID_LSB +: TID_W]),
        .rd_data (cfg_rd_data)
    );

    assign s1_cfg = cfg_entry_t'(cfg_rd_data);

    always_comb begin
        s1_valid_d     = phv_valid_in;
        s1_val_valid_d = val_valid_in;
        s1_phv_d       = phv_in;
        s1_val_d       = val_in[KEY_LEN-1:COND_W];
    end

    // Within each class the b slot is written first so an a slot at the same index wins.
    always_comb begin
        slot_en = s1_cfg.mask & {MASK_W{s1_val_valid_q}};
        merged  = s1_phv_q;
        for (int c = 0; c < NUM_CONT; c++) begin
            if (slot_en[SLOT_16B] && (s1_cfg.off16b == c[OFF_W-1:0]))
                merged[BASE16 + c*W16 +: W16] = s1_val_q[P16B +: W16];
            if (slot_en[SLOT_16A] && (s1_cfg.off16a == c[OFF_W-1:0]))
                merged[BASE16 + c*W16 +: W16] = s1_val_q[P16A +: W16];
            if (slot_en[SLOT_32B] && (s1_cfg.off32b == c[OFF_W-1:0]))
                merged[BASE32 + c*W32 +: W32] = s1_val_q[P32B +: W32];
            if (slot_en[SLOT_32A] && (s1_cfg.off32a == c[OFF_W-1:0]))
                merged[BASE32 + c*W32 +: W32] = s1_val_q[P32A +: W32];
            if (slot_en[SLOT_48B] && (s1_cfg.off48b == c[OFF_W-1:0]))
                merged[BASE48 + c*W48 +: W48] = s1_val_q[P48B +: W48];
            if (slot_en[SLOT_48A] && (s1_cfg.off48a == c[OFF_W-1:0]))
                merged[BASE48 + c*W48 +: W48] = s1_val_q[P48A +: W48];
        end
        phv_valid_out_d = s1_valid_q;
        phv_out_d       = s1_valid_q ? merged : phv_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q      <= 1'b0;
            s1_val_valid_q  <= 1'b0;
            s1_phv_q        <= '0;
            s1_val_q        <= '0;
            phv_out_q       <= '0;
            phv_valid_out_q <= 1'b0;
        end else begin
            s1_valid_q      <= s1_valid_d;
            s1_val_valid_q  <= s1_val_valid_d;
            s1_phv_q        <= s1_phv_d;
            s1_val_q        <= s1_val_d;
            phv_out_q       <= phv_out_d;
            phv_valid_out_q <= phv_valid_out_d;
        end
    end

    assign phv_out       = phv_out_q;
    assign phv_valid_out = phv_valid_out_q;

`ifdef KEY_WB_CONFLICT_CHK_EN
    logic conflict_d, conflict_q;

    always_comb begin
        conflict_d = s1_valid_q & (
            (slot_en[SLOT_16A] & slot_en[SLOT_16B] & (s1_cfg.off16a == s1_cfg.off16b)) |
            (slot_en[SLOT_32A] & slot_en[SLOT_32B] & (s1_cfg.off32a == s1_cfg.off32b)) |
            (slot_en[SLOT_48A] & slot_en[SLOT_48B] & (s1_cfg.off48a == s1_cfg.off48b)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_out = conflict_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_writeback.sv
// =============================================================================
// Module   : tb_key_writeback
// Purpose  : Self-checking bench for key_writeback against a container-array model.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_key_writeback;

    localparam int P = 1124;
    localparam int K = 197;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [P-1:0] phv_in = '0;
    logic         phv_valid_in = 1'b0;
    logic [K-1:0] val_in = '0;
    logic         val_valid_in = 1'b0;
    logic         cfg_wr_en = 1'b0;
    logic [3:0]   cfg_addr = '0;
    logic [23:0]  cfg_data = '0;
    logic [P-1:0] phv_out;
    logic         phv_valid_out;
`ifdef KEY_WB_CONFLICT_CHK_EN
    logic         conflict_out;
`endif

    int checks = 0;
    int failures = 0;

    // Model state: per-tenant offsets per slot (0=16b,1=16a,2=32b,3=32a,4=48b,5=48a) and masks
    bit [2:0]     m_off [16][6];
    bit [5:0]     m_mask[16];
    bit           pend_v;
    logic [P-1:0] pend_phv;
    bit           pend_conf;
    bit           exp_valid;
    logic [P-1:0] exp_phv;
    bit           exp_conf;

    key_writeback dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .phv_in        (phv_in),
        .phv_valid_in  (phv_valid_in),
        .val_in        (val_in),
        .val_valid_in  (val_valid_in),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .phv_out       (phv_out),
`ifdef KEY_WB_CONFLICT_CHK_EN
        .conflict_out  (conflict_out),
`endif
        .phv_valid_out (phv_valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [P-1:0] rand_phv(input logic [3:0] tid);
        logic [P-1:0] r;
        for (int i = 0; i < P; i++) r[i] = 1'($urandom_range(0, 1));
        r[3:0] = tid;
        return r;
    endfunction

    function automatic logic [K-1:0] rand_key();
        logic [K-1:0] r;
        for (int i = 0; i < K; i++) r[i] = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic int win(input logic [P-1:0] a, input logic [P-1:0] b);
        for (int i = 0; i < P; i++) if (a[i] !== b[i]) return (i > P - 32) ? P - 32 : i;
        return 0;
    endfunction

    task automatic model_clear();
        for (int t = 0; t < 16; t++) begin
            m_mask[t] = '0;
            for (int s = 0; s < 6; s++) m_off[t][s] = '0;
        end
        pend_v = 0; pend_phv = '0; pend_conf = 0;
        exp_valid = 0; exp_phv = '0; exp_conf = 0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [23:0] d);
        m_mask[a]   = d[5:0];
        m_off[a][0] = d[8:6];
        m_off[a][1] = d[11:9];
        m_off[a][2] = d[14:12];
        m_off[a][3] = d[17:15];
        m_off[a][4] = d[20:18];
        m_off[a][5] = d[23:21];
    endtask

    task automatic model_merge(input logic [P-1:0] p, input logic [K-1:0] k, input bit vv,
                               output logic [P-1:0] r, output bit cf);
        logic [47:0] c48[8];
        logic [31:0] c32[8];
        logic [15:0] c16[8];
        bit [2:0]    o[6];
        bit [5:0]    m;
        int          t;
        t = int'(p[3:0]);
        for (int s = 0; s < 6; s++) o[s] = m_off[t][s];
        m = vv ? m_mask[t] : 6'h0;
        for (int i = 0; i < 8; i++) begin
            c16[i] = p[356 + 16*i +: 16];
            c32[i] = p[484 + 32*i +: 32];
            c48[i] = p[740 + 48*i +: 48];
        end
        if (m[0]) c16[o[0]] = k[20:5];
        if (m[1]) c16[o[1]] = k[36:21];
        if (m[2]) c32[o[2]] = k[68:37];
        if (m[3]) c32[o[3]] = k[100:69];
        if (m[4]) c48[o[4]] = k[148:101];
        if (m[5]) c48[o[5]] = k[196:149];
        cf = (m[0] && m[1] && o[0] == o[1]) || (m[2] && m[3] && o[2] == o[3]) ||
             (m[4] && m[5] && o[4] == o[5]);
        r = p;
        for (int i = 0; i < 8; i++) begin
            r[356 + 16*i +: 16] = c16[i];
            r[484 + 32*i +: 32] = c32[i];
            r[740 + 48*i +: 48] = c48[i];
        end
    endtask

    // One clock of stimulus; afterwards exp_* describe what the DUT must show now.
    task automatic step(input bit v, input logic [P-1:0] p, input logic [K-1:0] k, input bit vv,
                        input bit wr, input logic [3:0] a, input logic [23:0] d);
        logic [P-1:0] r;
        bit           cf;
        phv_in = p; phv_valid_in = v; val_in = k; val_valid_in = vv;
        cfg_wr_en = wr; cfg_addr = a; cfg_data = d;
        model_merge(p, k, vv, r, cf);
        @(posedge clk);
        #1;
        exp_valid = pend_v;
        if (pend_v) exp_phv = pend_phv;
        exp_conf = pend_v && pend_conf;
        pend_v = v; pend_phv = r; pend_conf = cf;
        if (wr) model_write(a, d);
    endtask

    task automatic idle();
        step(0, '0, '0, 0, 0, 4'd0, 24'd0);
    endtask

    task automatic test_reset();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (phv_valid_out !== 1'b0) begin
            failures++; $display("FAIL reset valid got=%b exp=0", phv_valid_out);
        end
        checks++;
        if (phv_out !== '0) begin
            failures++; $display("FAIL reset phv_out got=%h exp=0", phv_out[win(phv_out, '0) +: 32]);
        end
`ifdef KEY_WB_CONFLICT_CHK_EN
        checks++;
        if (conflict_out !== 1'b0) begin
            failures++; $display("FAIL reset conflict got=%b exp=0", conflict_out);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        logic [P-1:0] p;
        for (int n = 0; n < 7; n++) begin
            p = rand_phv(4'($urandom_range(0, 15)));
            if (n == 0) p[P-1:356] = '0;
            if (n < 5) step(1, p, rand_key(), 1, 0, 4'd0, 24'd0);
            else idle();
            checks++;
            if (phv_valid_out !== exp_valid) begin
                failures++; $display("FAIL passthrough valid got=%b exp=%b", phv_valid_out, exp_valid);
            end
            checks++;
            if (phv_out !== exp_phv) begin
                failures++; $display("FAIL passthrough phv_out got=%h exp=%h",
                    phv_out[win(phv_out, exp_phv) +: 32], exp_phv[win(phv_out, exp_phv) +: 32]);
            end
        end
    endtask

    // Directed writeback: checks literal container contents as well as the model.
    task automatic test_directed(input string nm, input logic [23:0] d, input int ia, input int ib,
                                 input bit want_conf);
        logic [K-1:0] k;
        k = {48'hAAAAAAAAAAAA, 48'h555555555555, 32'h11111111, 32'h22222222,
             16'h3333, 16'h4444, 5'h1F};
        for (int n = 0; n < 3; n++) begin
            if (n == 0) step(0, '0, '0, 0, 1, 4'd0, d);
            else if (n == 1) step(1, rand_phv(4'd0), k, 1, 0, 4'd0, 24'd0);
            else idle();
            checks++;
            if (phv_valid_out !== exp_valid) begin
                failures++; $display("FAIL %s valid got=%b exp=%b", nm, phv_valid_out, exp_valid);
            end
            checks++;
            if (phv_out !== exp_phv) begin
                failures++; $display("FAIL %s phv_out got=%h exp=%h", nm,
                    phv_out[win(phv_out, exp_phv) +: 32], exp_phv[win(phv_out, exp_phv) +: 32]);
            end
`ifdef KEY_WB_CONFLICT_CHK_EN
            checks++;
            if (conflict_out !== (n == 2 && want_conf)) begin
                failures++; $display("FAIL %s conflict got=%b exp=%b", nm, conflict_out, (n == 2 && want_conf));
            end
`endif
        end
        checks++;
        if (phv_out[740 + 48*ia +: 48] !== 48'hAAAAAAAAAAAA) begin
            failures++; $display("FAIL %s c48[%0d] got=%h exp=aaaaaaaaaaaa", nm, ia, phv_out[740 + 48*ia +: 48]);
        end
        checks++;
        if (phv_out[484 + 32*ia +: 32] !== 32'h11111111) begin
            failures++; $display("FAIL %s c32[%0d] got=%h exp=11111111", nm, ia, phv_out[484 + 32*ia +: 32]);
        end
        checks++;
        if (phv_out[356 + 16*ia +: 16] !== 16'h3333) begin
            failures++; $display("FAIL %s c16[%0d] got=%h exp=3333", nm, ia, phv_out[356 + 16*ia +: 16]);
        end
        if (ib != ia) begin
            checks++;
            if ({phv_out[740 + 48*ib +: 48], phv_out[484 + 32*ib +: 32], phv_out[356 + 16*ib +: 16]} !==
                {48'h555555555555, 32'h22222222, 16'h4444}) begin
                failures++; $display("FAIL %s b-slots[%0d] got=%h %h %h", nm, ib, phv_out[740 + 48*ib +: 48],
                    phv_out[484 + 32*ib +: 32], phv_out[356 + 16*ib +: 16]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] d;
        d = {18'($urandom), 6'h20};
        for (int n = 0; n < 5; n++) begin
            case (n)
                0: step(0, '0, '0, 0, 1, 4'd3, d);
                1: step(1, rand_phv(4'd3), rand_key(), 1, 0, 4'd0, 24'd0);
                2: step(1, rand_phv(4'd0), rand_key(), 1, 0, 4'd0, 24'd0);
                default: idle();
            endcase
            checks++;
            if (phv_valid_out !== exp_valid) begin
                failures++; $display("FAIL back_to_back valid got=%b exp=%b", phv_valid_out, exp_valid);
            end
            checks++;
            if (phv_out !== exp_phv) begin
                failures++; $display("FAIL back_to_back phv_out got=%h exp=%h",
                    phv_out[win(phv_out, exp_phv) +: 32], exp_phv[win(phv_out, exp_phv) +: 32]);
            end
        end
    endtask

    task automatic test_cfg_collision();
        logic [23:0] d;
        d = {18'($urandom), 6'h3F};
        for (int n = 0; n < 4; n++) begin
            case (n)
                0: step(1, rand_phv(4'd0), rand_key(), 1, 1, 4'd0, d);
                1: step(1, rand_phv(4'd0), rand_key(), 1, 0, 4'd0, 24'd0);
                default: idle();
            endcase
            checks++;
            if (phv_valid_out !== exp_valid) begin
                failures++; $display("FAIL cfg_collision valid got=%b exp=%b", phv_valid_out, exp_valid);
            end
            checks++;
            if (phv_out !== exp_phv) begin
                failures++; $display("FAIL cfg_collision phv_out got=%h exp=%h",
                    phv_out[win(phv_out, exp_phv) +: 32], exp_phv[win(phv_out, exp_phv) +: 32]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 3) != 0, rand_phv(4'($urandom_range(0, 3))), rand_key(),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 3)), 24'($urandom));
            checks++;
            if (phv_valid_out !== exp_valid) begin
                failures++; $display("FAIL random[%0d] valid got=%b exp=%b", n, phv_valid_out, exp_valid);
            end
            checks++;
            if (phv_out !== exp_phv) begin
                failures++; $display("FAIL random[%0d] phv_out got=%h exp=%h", n,
                    phv_out[win(phv_out, exp_phv) +: 32], exp_phv[win(phv_out, exp_phv) +: 32]);
            end
`ifdef KEY_WB_CONFLICT_CHK_EN
            checks++;
            if (conflict_out !== exp_conf) begin
                failures++; $display("FAIL random[%0d] conflict got=%b exp=%b", n, conflict_out, exp_conf);
            end
`endif
        end
    endtask

    task automatic test_reset_midflight();
        logic [P-1:0] p;
        step(0, '0, '0, 0, 1, 4'd0, {18'($urandom), 6'h3F});
        step(1, rand_phv(4'd0), rand_key(), 1, 0, 4'd0, 24'd0);
        rst_n = 1'b0;
        phv_valid_in = 1'b0;
        cfg_wr_en = 1'b0;
        model_clear();
        #1;
        checks++;
        if (phv_valid_out !== 1'b0 || phv_out !== '0) begin
            failures++; $display("FAIL midflight_reset outputs got valid=%b exp valid=0", phv_valid_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        p = rand_phv(4'd0);
        for (int n = 0; n < 6; n++) begin
            if (n == 3) step(1, p, rand_key(), 1, 0, 4'd0, 24'd0);
            else idle();
            checks++;
            if (phv_valid_out !== exp_valid) begin
                failures++; $display("FAIL midflight valid[%0d] got=%b exp=%b", n, phv_valid_out, exp_valid);
            end
        end
        checks++;
        if (phv_out !== p) begin
            failures++; $display("FAIL midflight table_cleared got=%h exp=%h",
                phv_out[win(phv_out, p) +: 32], p[win(phv_out, p) +: 32]);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_directed("cfg_676767", {3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 6'h3F}, 6, 7, 1'b0);
        test_directed("same_index", {3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 6'h3F}, 5, 5, 1'b1);
        test_back_to_back();
        test_cfg_collision();
        test_random();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
